// File: rtl/vending_machine_param_if.sv
// Bundle of the vending controller's front-end and back-end signals.
//   master : coin validator / dispenser / hopper side (drives coin, cancel,
//            dispense_ack, change_ready; observes everything else)
//   slave  : the vending controller itself
// Coin codes: 3'b001=1, 3'b010=2, 3'b101=5, 3'b000=none, other=invalid.
interface vending_machine_param_if #(
  parameter int CREDIT_W = 5,
  parameter int COUNT_W  = 8
);
  logic [2:0]          coin;
  logic                cancel;
  logic                dispense_ack;
  logic                change_ready;
  logic                coin_accept;
  logic                coin_reject;
  logic [CREDIT_W-1:0] credit;
  logic                dispense;
  logic                change_valid;
  logic [2:0]          change_coin;
  logic                busy;
  logic [COUNT_W-1:0]  vend_count;

  modport master (
    output coin, cancel, dispense_ack, change_ready,
    input  coin_accept, coin_reject, credit, dispense, change_valid,
           change_coin, busy, vend_count
  );

  modport slave (
    input  coin, cancel, dispense_ack, change_ready,
    output coin_accept, coin_reject, credit, dispense, change_valid,
           change_coin, busy, vend_count
  );
endinterface

// File: rtl/vending_machine_param.sv
// Parametrised coin vending controller with binary credit, cancel/refund,
// dispense handshake and serial greedy (5/2/1) change return.
// Ports:
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   bus (slave)  coin/cancel/dispense_ack/change_ready in;
//                coin_accept/coin_reject pulses, credit, dispense,
//                change_valid/change_coin, busy, vend_count out
// All outputs are registered: a sampled input shows its effect one cycle later.
// PRICE must lie in 1..MAX_CREDIT and MAX_CREDIT < 2**CREDIT_W.
//
// state   | meaning
// --------+-----------------------------------------------------------
// COLLECT | accepting coins; cancel with credit refunds via CHANGE
// VEND    | dispense held high until dispense_ack
// CHANGE  | presenting one change coin per change_ready handshake
module vending_machine_param #(
  parameter int PRICE      = 7,
  parameter int MAX_CREDIT = 15,
  parameter int CREDIT_W   = 5,
  parameter int COUNT_W    = 8
) (
  input logic                    clk,
  input logic                    reset_n,
  vending_machine_param_if.slave bus
);

  typedef enum logic [1:0] {COLLECT, VEND, CHANGE} state_t;

  // Credit arithmetic is one bit wider so coin sums can't wrap before the
  // MAX_CREDIT compare.
  localparam logic [CREDIT_W:0] PRICE_X = (CREDIT_W+1)'(PRICE);
  localparam logic [CREDIT_W:0] MAX_X   = (CREDIT_W+1)'(MAX_CREDIT);
  localparam logic [CREDIT_W:0] ONE_X   = (CREDIT_W+1)'(1);
  localparam logic [CREDIT_W:0] TWO_X   = (CREDIT_W+1)'(2);
  localparam logic [CREDIT_W:0] FIVE_X  = (CREDIT_W+1)'(5);

  function automatic logic [CREDIT_W:0] coin_value(input logic [2:0] code);
    logic [CREDIT_W:0] v;
    case (code)
      3'b001:  v = ONE_X;
      3'b010:  v = TWO_X;
      3'b101:  v = FIVE_X;
      default: v = '0;
    endcase
    return v;
  endfunction

  // Largest denomination not exceeding the amount still owed.
  function automatic logic [2:0] pick_coin(input logic [CREDIT_W:0] amt);
    logic [2:0] c;
    if (amt >= FIVE_X)     c = 3'b101;
    else if (amt >= TWO_X) c = 3'b010;
    else                   c = 3'b001;
    return c;
  endfunction

  state_t              state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic                dispense_q, dispense_d;
  logic                change_valid_q, change_valid_d;
  logic [2:0]          change_coin_q, change_coin_d;
  logic                coin_accept_q, coin_accept_d;
  logic                coin_reject_q, coin_reject_d;
  logic                busy_q, busy_d;
  logic [COUNT_W-1:0]  vend_count_q, vend_count_d;

  logic [CREDIT_W:0] coin_val;
  logic              coin_present;
  logic              coin_valid;
  logic [CREDIT_W:0] credit_x;
  logic [CREDIT_W:0] sum_x;
  logic [CREDIT_W:0] after_vend_x;
  logic [CREDIT_W:0] after_change_x;

  assign coin_val       = coin_value(bus.coin);
  assign coin_present   = (bus.coin != 3'b000);
  assign coin_valid     = (coin_val != '0);
  assign credit_x       = {1'b0, credit_q};
  assign sum_x          = credit_x + coin_val;
  assign after_vend_x   = credit_x - PRICE_X;
  assign after_change_x = credit_x - coin_value(change_coin_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= COLLECT;
      credit_q       <= '0;
      dispense_q     <= 1'b0;
      change_valid_q <= 1'b0;
      change_coin_q  <= 3'b000;
      coin_accept_q  <= 1'b0;
      coin_reject_q  <= 1'b0;
      busy_q         <= 1'b0;
      vend_count_q   <= '0;
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      dispense_q     <= dispense_d;
      change_valid_q <= change_valid_d;
      change_coin_q  <= change_coin_d;
      coin_accept_q  <= coin_accept_d;
      coin_reject_q  <= coin_reject_d;
      busy_q         <= busy_d;
      vend_count_q   <= vend_count_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    dispense_d     = dispense_q;
    change_valid_d = change_valid_q;
    change_coin_d  = change_coin_q;
    coin_accept_d  = 1'b0;
    coin_reject_d  = 1'b0;
    vend_count_d   = vend_count_q;

    case (state_q)
      COLLECT: begin
        if (coin_present) begin
          // A coin arriving alongside cancel is handed back, not credited.
          if (coin_valid && !bus.cancel && (sum_x <= MAX_X)) begin
            coin_accept_d = 1'b1;
            credit_d      = sum_x[CREDIT_W-1:0];
            if (sum_x >= PRICE_X) begin
              state_d    = VEND;
              dispense_d = 1'b1;
            end
          end else begin
            coin_reject_d = 1'b1;
          end
        end
        if (bus.cancel && (credit_q != '0)) begin
          state_d        = CHANGE;
          change_valid_d = 1'b1;
          change_coin_d  = pick_coin(credit_x);
        end
      end

      VEND: begin
        coin_reject_d = coin_present;
        if (bus.dispense_ack) begin
          dispense_d   = 1'b0;
          credit_d     = after_vend_x[CREDIT_W-1:0];
          vend_count_d = vend_count_q + COUNT_W'(1);
          if (after_vend_x != '0) begin
            state_d        = CHANGE;
            change_valid_d = 1'b1;
            change_coin_d  = pick_coin(after_vend_x);
          end else begin
            state_d = COLLECT;
          end
        end
      end

      CHANGE: begin
        coin_reject_d = coin_present;
        if (bus.change_ready) begin
          credit_d = after_change_x[CREDIT_W-1:0];
          if (after_change_x != '0) begin
            change_coin_d = pick_coin(after_change_x);
          end else begin
            change_valid_d = 1'b0;
            change_coin_d  = 3'b000;
            state_d        = COLLECT;
          end
        end
      end

      default: begin
        state_d = COLLECT;
      end
    endcase

    busy_d = (state_d != COLLECT);
  end

  assign bus.credit       = credit_q;
  assign bus.dispense     = dispense_q;
  assign bus.change_valid = change_valid_q;
  assign bus.change_coin  = change_coin_q;
  assign bus.coin_accept  = coin_accept_q;
  assign bus.coin_reject  = coin_reject_q;
  assign bus.busy         = busy_q;
  assign bus.vend_count   = vend_count_q;

endmodule

// File: tb/tb_vending_machine_param.sv
// Bench for vending_machine_param: three instances (default, PRICE=12,
// COUNT_W=2). Inputs change on the falling edge, outputs are read on the
// following falling edge after the rising edge has registered them.
module tb_vending_machine_param;
  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  logic [4:0] exp_credit_q[$];
  logic [2:0] exp_change_q[$];

  always #5 clk = ~clk;

  vending_machine_param_if                b0 ();
  vending_machine_param_if                b1 ();
  vending_machine_param_if #(.COUNT_W(2)) b2 ();

  vending_machine_param u0 (.clk(clk), .reset_n(reset_n), .bus(b0));
  vending_machine_param #(.PRICE(12)) u1 (.clk(clk), .reset_n(reset_n), .bus(b1));
  vending_machine_param #(.COUNT_W(2)) u2 (.clk(clk), .reset_n(reset_n), .bus(b2));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    b0.coin = 3'b000; b0.cancel = 1'b0; b0.dispense_ack = 1'b0; b0.change_ready = 1'b0;
    b1.coin = 3'b000; b1.cancel = 1'b0; b1.dispense_ack = 1'b0; b1.change_ready = 1'b0;
    b2.coin = 3'b000; b2.cancel = 1'b0; b2.dispense_ack = 1'b0; b2.change_ready = 1'b0;
    reset_n = 1'b0;
    repeat (2) tick();
    checks++; if (b0.credit !== 5'd0) begin errors++; $display("FAIL reset_credit: got %0d expected 0", b0.credit); end
    checks++; if (b0.dispense !== 1'b0) begin errors++; $display("FAIL reset_dispense: got %b expected 0", b0.dispense); end
    checks++; if (b0.change_valid !== 1'b0 || b0.change_coin !== 3'b000) begin errors++; $display("FAIL reset_change: got valid=%b coin=%b expected 0/000", b0.change_valid, b0.change_coin); end
    checks++; if (b0.busy !== 1'b0 || b0.vend_count !== 8'd0) begin errors++; $display("FAIL reset_busy_count: got busy=%b count=%0d expected 0/0", b0.busy, b0.vend_count); end
    checks++; if (b0.coin_accept !== 1'b0 || b0.coin_reject !== 1'b0) begin errors++; $display("FAIL reset_pulses: got acc=%b rej=%b expected 0/0", b0.coin_accept, b0.coin_reject); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_exact_vend();
    logic [2:0] cs[2] = '{3'b010, 3'b101};
    logic [4:0] cr[2] = '{5'd2, 5'd7};
    logic [4:0] e;
    for (int i = 0; i < 2; i++) begin
      exp_credit_q.push_back(cr[i]);
      b0.coin = cs[i]; tick(); b0.coin = 3'b000;
      checks++; if (b0.coin_accept !== 1'b1) begin errors++; $display("FAIL exact_accept%0d: got %b expected 1", i, b0.coin_accept); end
      e = exp_credit_q.pop_front();
      checks++; if (b0.credit !== e) begin errors++; $display("FAIL exact_credit%0d: got %0d expected %0d", i, b0.credit, e); end
    end
    checks++; if (b0.dispense !== 1'b1 || b0.busy !== 1'b1) begin errors++; $display("FAIL exact_dispense: got disp=%b busy=%b expected 1/1", b0.dispense, b0.busy); end
    tick();
    checks++; if (b0.dispense !== 1'b1) begin errors++; $display("FAIL exact_hold: got %b expected 1", b0.dispense); end
    b0.dispense_ack = 1'b1; tick(); b0.dispense_ack = 1'b0;
    checks++; if (b0.dispense !== 1'b0 || b0.credit !== 5'd0) begin errors++; $display("FAIL exact_ack: got disp=%b credit=%0d expected 0/0", b0.dispense, b0.credit); end
    checks++; if (b0.change_valid !== 1'b0 || b0.busy !== 1'b0) begin errors++; $display("FAIL exact_idle: got valid=%b busy=%b expected 0/0", b0.change_valid, b0.busy); end
    checks++; if (b0.vend_count !== 8'd1) begin errors++; $display("FAIL exact_count: got %0d expected 1", b0.vend_count); end
  endtask

  task automatic test_vend_change();
    logic [4:0] e;
    logic [2:0] c;
    for (int i = 0; i < 2; i++) begin
      exp_credit_q.push_back(i == 0 ? 5'd5 : 5'd10);
      b0.coin = 3'b101; tick(); b0.coin = 3'b000;
      e = exp_credit_q.pop_front();
      checks++; if (b0.coin_accept !== 1'b1 || b0.credit !== e) begin errors++; $display("FAIL vc_coin%0d: got acc=%b credit=%0d expected 1/%0d", i, b0.coin_accept, b0.credit, e); end
    end
    checks++; if (b0.dispense !== 1'b1) begin errors++; $display("FAIL vc_dispense: got %b expected 1", b0.dispense); end
    b0.coin = 3'b101; tick(); b0.coin = 3'b000;
    checks++; if (b0.coin_reject !== 1'b1 || b0.coin_accept !== 1'b0 || b0.credit !== 5'd10) begin errors++; $display("FAIL vc_vend_reject: got rej=%b acc=%b credit=%0d expected 1/0/10", b0.coin_reject, b0.coin_accept, b0.credit); end
    exp_change_q.push_back(3'b010); exp_credit_q.push_back(5'd1);
    exp_change_q.push_back(3'b001); exp_credit_q.push_back(5'd0);
    b0.dispense_ack = 1'b1; tick(); b0.dispense_ack = 1'b0;
    checks++; if (b0.credit !== 5'd3 || b0.vend_count !== 8'd2 || b0.dispense !== 1'b0) begin errors++; $display("FAIL vc_ack: got credit=%0d count=%0d disp=%b expected 3/2/0", b0.credit, b0.vend_count, b0.dispense); end
    for (int k = 0; k < 5; k++) begin
      checks++; if (b0.change_valid !== 1'b1 || b0.change_coin !== 3'b010) begin errors++; $display("FAIL vc_stable%0d: got valid=%b coin=%b expected 1/010", k, b0.change_valid, b0.change_coin); end
      tick();
    end
    while (exp_change_q.size() > 0) begin
      c = exp_change_q.pop_front();
      checks++; if (b0.change_valid !== 1'b1 || b0.change_coin !== c) begin errors++; $display("FAIL vc_change: got valid=%b coin=%b expected 1/%b", b0.change_valid, b0.change_coin, c); end
      b0.change_ready = 1'b1; tick(); b0.change_ready = 1'b0;
      e = exp_credit_q.pop_front();
      checks++; if (b0.credit !== e) begin errors++; $display("FAIL vc_change_credit: got %0d expected %0d", b0.credit, e); end
    end
    checks++; if (b0.change_valid !== 1'b0 || b0.busy !== 1'b0) begin errors++; $display("FAIL vc_done: got valid=%b busy=%b expected 0/0", b0.change_valid, b0.busy); end
  endtask

  task automatic test_cancel();
    logic [4:0] e;
    logic [2:0] c;
    for (int i = 0; i < 2; i++) begin
      exp_credit_q.push_back(i == 0 ? 5'd2 : 5'd4);
      b0.coin = 3'b010; tick(); b0.coin = 3'b000;
      e = exp_credit_q.pop_front();
      checks++; if (b0.credit !== e) begin errors++; $display("FAIL cancel_coin%0d: got %0d expected %0d", i, b0.credit, e); end
    end
    exp_change_q.push_back(3'b010); exp_credit_q.push_back(5'd2);
    exp_change_q.push_back(3'b010); exp_credit_q.push_back(5'd0);
    b0.coin = 3'b001; b0.cancel = 1'b1; tick(); b0.coin = 3'b000; b0.cancel = 1'b0;
    checks++; if (b0.coin_reject !== 1'b1 || b0.coin_accept !== 1'b0 || b0.credit !== 5'd4) begin errors++; $display("FAIL cancel_coin_reject: got rej=%b acc=%b credit=%0d expected 1/0/4", b0.coin_reject, b0.coin_accept, b0.credit); end
    checks++; if (b0.busy !== 1'b1 || b0.dispense !== 1'b0) begin errors++; $display("FAIL cancel_state: got busy=%b disp=%b expected 1/0", b0.busy, b0.dispense); end
    b0.coin = 3'b101; b0.cancel = 1'b1; tick(); b0.coin = 3'b000; b0.cancel = 1'b0;
    checks++; if (b0.coin_reject !== 1'b1 || b0.credit !== 5'd4) begin errors++; $display("FAIL cancel_change_reject: got rej=%b credit=%0d expected 1/4", b0.coin_reject, b0.credit); end
    while (exp_change_q.size() > 0) begin
      c = exp_change_q.pop_front();
      checks++; if (b0.change_valid !== 1'b1 || b0.change_coin !== c) begin errors++; $display("FAIL cancel_change: got valid=%b coin=%b expected 1/%b", b0.change_valid, b0.change_coin, c); end
      b0.change_ready = 1'b1; tick(); b0.change_ready = 1'b0;
      e = exp_credit_q.pop_front();
      checks++; if (b0.credit !== e) begin errors++; $display("FAIL cancel_credit: got %0d expected %0d", b0.credit, e); end
    end
    checks++; if (b0.change_valid !== 1'b0 || b0.busy !== 1'b0 || b0.vend_count !== 8'd2) begin errors++; $display("FAIL cancel_done: got valid=%b busy=%b count=%0d expected 0/0/2", b0.change_valid, b0.busy, b0.vend_count); end
    b0.cancel = 1'b1; tick(); b0.cancel = 1'b0;
    checks++; if (b0.busy !== 1'b0 || b0.change_valid !== 1'b0) begin errors++; $display("FAIL cancel_zero: got busy=%b valid=%b expected 0/0", b0.busy, b0.change_valid); end
  endtask

  task automatic test_invalid();
    logic [2:0] cs[3]  = '{3'b011, 3'b001, 3'b110};
    logic       acc[3] = '{1'b0, 1'b1, 1'b0};
    logic [4:0] cr[3]  = '{5'd0, 5'd1, 5'd1};
    logic [4:0] e;
    for (int i = 0; i < 3; i++) begin
      exp_credit_q.push_back(cr[i]);
      b0.coin = cs[i]; tick(); b0.coin = 3'b000;
      checks++; if (b0.coin_accept !== acc[i] || b0.coin_reject !== !acc[i]) begin errors++; $display("FAIL invalid_pulse%0d: got acc=%b rej=%b expected %b/%b", i, b0.coin_accept, b0.coin_reject, acc[i], !acc[i]); end
      e = exp_credit_q.pop_front();
      checks++; if (b0.credit !== e) begin errors++; $display("FAIL invalid_credit%0d: got %0d expected %0d", i, b0.credit, e); end
    end
    b0.cancel = 1'b1; tick(); b0.cancel = 1'b0;
    checks++; if (b0.change_valid !== 1'b1 || b0.change_coin !== 3'b001) begin errors++; $display("FAIL invalid_refund: got valid=%b coin=%b expected 1/001", b0.change_valid, b0.change_coin); end
    b0.change_ready = 1'b1; tick(); b0.change_ready = 1'b0;
    checks++; if (b0.change_valid !== 1'b0 || b0.credit !== 5'd0) begin errors++; $display("FAIL invalid_refund_done: got valid=%b credit=%0d expected 0/0", b0.change_valid, b0.credit); end
  endtask

  task automatic test_price12();
    logic [2:0] cs[5]  = '{3'b101, 3'b101, 3'b001, 3'b101, 3'b001};
    logic       acc[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [4:0] cr[5]  = '{5'd5, 5'd10, 5'd11, 5'd11, 5'd12};
    logic [4:0] e;
    for (int i = 0; i < 5; i++) begin
      exp_credit_q.push_back(cr[i]);
      b1.coin = cs[i]; tick(); b1.coin = 3'b000;
      checks++; if (b1.coin_accept !== acc[i] || b1.coin_reject !== !acc[i]) begin errors++; $display("FAIL p12_pulse%0d: got acc=%b rej=%b expected %b/%b", i, b1.coin_accept, b1.coin_reject, acc[i], !acc[i]); end
      e = exp_credit_q.pop_front();
      checks++; if (b1.credit !== e) begin errors++; $display("FAIL p12_credit%0d: got %0d expected %0d", i, b1.credit, e); end
    end
    checks++; if (b1.dispense !== 1'b1) begin errors++; $display("FAIL p12_dispense: got %b expected 1", b1.dispense); end
    b1.dispense_ack = 1'b1; tick(); b1.dispense_ack = 1'b0;
    checks++; if (b1.credit !== 5'd0 || b1.change_valid !== 1'b0 || b1.busy !== 1'b0 || b1.vend_count !== 8'd1) begin errors++; $display("FAIL p12_ack: got credit=%0d valid=%b busy=%b count=%0d expected 0/0/0/1", b1.credit, b1.change_valid, b1.busy, b1.vend_count); end
  endtask

  task automatic test_count_wrap_and_reset();
    logic [1:0] ec;
    for (int v = 1; v <= 4; v++) begin
      b2.coin = 3'b101; tick();
      b2.coin = 3'b010; tick(); b2.coin = 3'b000;
      b2.dispense_ack = 1'b1; tick(); b2.dispense_ack = 1'b0;
      ec = 2'(v);
      checks++; if (b2.vend_count !== ec || b2.busy !== 1'b0) begin errors++; $display("FAIL wrap_count%0d: got count=%0d busy=%b expected %0d/0", v, b2.vend_count, b2.busy, ec); end
    end
    b2.coin = 3'b101; tick(); tick(); b2.coin = 3'b000;
    b2.dispense_ack = 1'b1; tick(); b2.dispense_ack = 1'b0;
    checks++; if (b2.change_valid !== 1'b1 || b2.credit !== 5'd3 || b2.vend_count !== 2'd1) begin errors++; $display("FAIL wrap_change: got valid=%b credit=%0d count=%0d expected 1/3/1", b2.change_valid, b2.credit, b2.vend_count); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (b2.change_valid !== 1'b0 || b2.change_coin !== 3'b000 || b2.credit !== 5'd0) begin errors++; $display("FAIL async_change: got valid=%b coin=%b credit=%0d expected 0/000/0", b2.change_valid, b2.change_coin, b2.credit); end
    checks++; if (b2.busy !== 1'b0 || b2.dispense !== 1'b0 || b2.vend_count !== 2'd0) begin errors++; $display("FAIL async_misc: got busy=%b disp=%b count=%0d expected 0/0/0", b2.busy, b2.dispense, b2.vend_count); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_exact_vend();
    test_vend_change();
    test_cancel();
    test_invalid();
    test_price12();
    test_count_wrap_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit, expected finish");
    $fatal(1, "time limit");
  end
endmodule
